ts_card_emitter: RTL and testbench

// Card-side model for the ISO7816-3 test bench: the answering end of the activation/TS check.

---
 rtl/ts_card_emitter.sv | 224 ++++++++++++++++++++++
 tb/tb_ts_card_emitter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ts_card_emitter.sv
// Card-side ISO7816-3 TS responder: follows the terminal's VDD/RST/CLK and, a programmable
// number of card-clock edges after RST release, sends one TS character on I/O.
module ts_card_emitter #(
    parameter int unsigned ETU_CLKS = 372,
    parameter int unsigned DELAY_W  = 16,
    parameter int unsigned ETU_W    = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               isoVdd,
    input  logic               isoReset,
    input  logic               isoClk,
    input  logic [DELAY_W-1:0] tsDelay,
    input  logic [7:0]         tsByte,
    input  logic               inverse,
    output logic               sioOut,
    output logic               sioOe,
    output logic               activated,
    output logic               busy,
    output logic               tsSent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_TX,
        S_GUARD,
        S_DONE
    } state_t;

    localparam logic [ETU_W-1:0]   ETU_LAST  = ETU_W'(ETU_CLKS - 1);
    localparam logic [3:0]         LAST_BIT  = 4'd9;
    localparam logic [3:0]         LAST_GT   = 4'd1;
    localparam logic [DELAY_W-1:0] DELAY_MAX = '1;

    logic [2:0] iso_clk_s_q, iso_clk_s_d;
    logic [1:0] vdd_s_q, vdd_s_d;
    logic [1:0] rst_s_q, rst_s_d;

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [DELAY_W-1:0] delay_lim_q, delay_lim_d;
    logic [ETU_W-1:0]   etu_cnt_q, etu_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [9:0]         frame_q, frame_d;
    logic               sio_out_q, sio_out_d;
    logic               sio_oe_q, sio_oe_d;
    logic               activated_q, activated_d;
    logic               busy_q, busy_d;
    logic               ts_sent_q, ts_sent_d;

    logic               iso_edge;
    logic               vdd_ok;
    logic               rst_hi;
    logic [DELAY_W-1:0] delay_inc;
    logic [3:0]         next_bit;
    logic [7:0]         byte_rev;
    logic [9:0]         frame_new;

    assign iso_edge = iso_clk_s_q[1] & ~iso_clk_s_q[2];
    assign vdd_ok   = vdd_s_q[1];
    assign rst_hi   = rst_s_q[1];

    always_comb begin
        iso_clk_s_d = {iso_clk_s_q[1:0], isoClk};
        vdd_s_d     = {vdd_s_q[0], isoVdd};
        rst_s_d     = {rst_s_q[0], isoReset};
    end

    // Frame is bit 0 = start, bits 1..8 = data in line order, bit 9 = parity, all as line levels.
    always_comb begin
        byte_rev = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            byte_rev[i] = tsByte[7-i];
        end
        if (inverse) begin
            frame_new = {~(^tsByte), ~byte_rev, 1'b0};
        end else begin
            frame_new = {^tsByte, tsByte, 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        delay_lim_d = delay_lim_q;
        etu_cnt_d   = etu_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        sio_out_d   = sio_out_q;
        sio_oe_d    = sio_oe_q;
        activated_d = activated_q;
        busy_d      = busy_q;
        ts_sent_d   = 1'b0;
        delay_inc   = (delay_cnt_q == DELAY_MAX) ? delay_cnt_q : delay_cnt_q + 1'b1;
        next_bit    = bit_cnt_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (vdd_ok && !rst_hi) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (rst_hi) begin
                    state_d     = S_DELAY;
                    delay_cnt_d = '0;
                    delay_lim_d = (tsDelay == '0) ? DELAY_W'(1) : tsDelay;
                    frame_d     = frame_new;
                    activated_d = 1'b1;
                end
            end
            S_DELAY: begin
                if (iso_edge) begin
                    delay_cnt_d = delay_inc;
                    if (delay_inc >= delay_lim_q) begin
                        state_d   = S_TX;
                        etu_cnt_d = '0;
                        bit_cnt_d = '0;
                        sio_out_d = frame_q[0];
                        sio_oe_d  = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end
            S_TX: begin
                if (iso_edge) begin
                    if (etu_cnt_q == ETU_LAST) begin
                        etu_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d   = S_GUARD;
                            bit_cnt_d = '0;
                            sio_out_d = 1'b1;
                            sio_oe_d  = 1'b0;
                            busy_d    = 1'b0;
                        end else begin
                            bit_cnt_d = next_bit;
                            sio_out_d = frame_q[next_bit];
                        end
                    end else begin
                        etu_cnt_d = etu_cnt_q + 1'b1;
                    end
                end
            end
            S_GUARD: begin
                if (iso_edge) begin
                    if (etu_cnt_q == ETU_LAST) begin
                        etu_cnt_d = '0;
                        if (bit_cnt_q == LAST_GT) begin
                            state_d   = S_DONE;
                            bit_cnt_d = '0;
                            ts_sent_d = 1'b1;
                        end else begin
                            bit_cnt_d = next_bit;
                        end
                    end else begin
                        etu_cnt_d = etu_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Loss of supply beats warm reset; both abandon any character in flight.
        if ((state_q != S_IDLE && !vdd_ok) ||
            (state_q inside {S_DELAY, S_TX, S_GUARD, S_DONE} && !rst_hi)) begin
            state_d     = vdd_ok ? S_ARMED : S_IDLE;
            delay_cnt_d = '0;
            etu_cnt_d   = '0;
            bit_cnt_d   = '0;
            sio_out_d   = 1'b1;
            sio_oe_d    = 1'b0;
            activated_d = 1'b0;
            busy_d      = 1'b0;
            ts_sent_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iso_clk_s_q <= '0;
            vdd_s_q     <= '0;
            rst_s_q     <= '0;
            state_q     <= S_IDLE;
            delay_cnt_q <= '0;
            delay_lim_q <= '0;
            etu_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '1;
            sio_out_q   <= 1'b1;
            sio_oe_q    <= 1'b0;
            activated_q <= 1'b0;
            busy_q      <= 1'b0;
            ts_sent_q   <= 1'b0;
        end else begin
            iso_clk_s_q <= iso_clk_s_d;
            vdd_s_q     <= vdd_s_d;
            rst_s_q     <= rst_s_d;
            state_q     <= state_d;
            delay_cnt_q <= delay_cnt_d;
            delay_lim_q <= delay_lim_d;
            etu_cnt_q   <= etu_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            sio_out_q   <= sio_out_d;
            sio_oe_q    <= sio_oe_d;
            activated_q <= activated_d;
            busy_q      <= busy_d;
            ts_sent_q   <= ts_sent_d;
        end
    end

    assign sioOut    = sio_out_q;
    assign sioOe     = sio_oe_q;
    assign activated = activated_q;
    assign busy      = busy_q;
    assign tsSent    = ts_sent_q;

endmodule

// File: tb/tb_ts_card_emitter.sv
// Directed bench for ts_card_emitter: walks each TS frame isoClk edge by edge against
// hand-written line levels, with warm-reset, supply-loss and system-reset aborts.
module tb_ts_card_emitter;

    localparam int E = 12;

    logic        clk;
    logic        reset;
    logic        isoVdd;
    logic        isoReset;
    logic        isoClk;
    logic [15:0] tsDelay;
    logic [7:0]  tsByte;
    logic        inverse;
    logic        sioOut;
    logic        sioOe;
    logic        activated;
    logic        busy;
    logic        tsSent;

    int checks = 0;
    int failures = 0;
    int sent_total = 0;

    ts_card_emitter #(
        .ETU_CLKS(E),
        .DELAY_W (16),
        .ETU_W   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .isoVdd   (isoVdd),
        .isoReset (isoReset),
        .isoClk   (isoClk),
        .tsDelay  (tsDelay),
        .tsByte   (tsByte),
        .inverse  (inverse),
        .sioOut   (sioOut),
        .sioOe    (sioOe),
        .activated(activated),
        .busy     (busy),
        .tsSent   (tsSent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Card clock at 1/8 of clk, phase-shifted so its edges never coincide with clk edges.
    initial begin
        isoClk = 1'b0;
        #2;
        forever #40 isoClk = ~isoClk;
    end

    always @(posedge clk) if (tsSent === 1'b1) sent_total <= sent_total + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_oe"}, 32'(sioOe), 0);
        chk({tag, "_out"}, 32'(sioOut), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_act"}, 32'(activated), 0);
        chk({tag, "_sent"}, 32'(tsSent), 0);
    endtask

    // abort_kind: 0 none, 1 isoReset low, 2 isoVdd low, 3 system reset; applied after edge abort_k.
    task automatic run_frame(input string tag, input int d, input logic [7:0] b, input logic inv,
                             input logic [9:0] fr, input int abort_k, input int abort_kind);
        int de, last, s0, sent_pre, sent_at;
        int bad_oe, bad_out, bad_busy, bad_act, bad_post;
        logic exp_oe, exp_out;
        bad_oe = 0; bad_out = 0; bad_busy = 0; bad_act = 0; bad_post = 0;
        sent_pre = -1; sent_at = -1;
        isoVdd = 1'b1;
        isoReset = 1'b0;
        repeat (4) @(negedge isoClk);
        tsDelay = d[15:0];
        tsByte = b;
        inverse = inv;
        de = (d == 0) ? 1 : d;
        last = de + 12 * E;
        #1 isoReset = 1'b1;
        s0 = sent_total;
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge isoClk);
            if (k == 2) begin
                tsDelay = 16'd7;
                tsByte = ~b;
                inverse = ~inv;
            end
            if (k < de || k >= de + 10 * E) begin
                exp_oe = 1'b0;
                exp_out = 1'b1;
            end else begin
                exp_oe = 1'b1;
                exp_out = fr[(k - de) / E];
            end
            if (sioOe !== exp_oe) bad_oe++;
            if (sioOut !== exp_out) bad_out++;
            if (busy !== exp_oe) bad_busy++;
            if (activated !== 1'b1) bad_act++;
            if (k == last - 1) sent_pre = sent_total - s0;
            if (k == last) sent_at = sent_total - s0;
            if (abort_k != 0 && k == abort_k) break;
        end
        chk({tag, "_oe_walk"}, bad_oe, 0);
        chk({tag, "_out_walk"}, bad_out, 0);
        chk({tag, "_busy_walk"}, bad_busy, 0);
        chk({tag, "_act_walk"}, bad_act, 0);
        if (abort_k == 0) begin
            chk({tag, "_sent_before_guard_end"}, sent_pre, 0);
            chk({tag, "_sent_at_guard_end"}, sent_at, 1);
            chk({tag, "_sent_total"}, sent_total - s0, 1);
        end else begin
            if (abort_kind == 1) begin
                #1 isoReset = 1'b0;
                repeat (4) @(posedge clk);
                #1;
            end else if (abort_kind == 2) begin
                #1 isoVdd = 1'b0;
                repeat (4) @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                #1;
            end
            chk_idle_outputs({tag, "_after_abort"});
            if (abort_kind == 3) begin
                @(negedge clk);
                reset = 1'b0;
            end
            for (int k = 0; k < 200; k++) begin
                @(negedge isoClk);
                if (sioOe !== 1'b0 || busy !== 1'b0 || activated !== 1'b0 || sioOut !== 1'b1)
                    bad_post++;
            end
            chk({tag, "_quiet_after_abort"}, bad_post, 0);
            chk({tag, "_no_sent"}, sent_total - s0, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        isoVdd = 1'b0;
        isoReset = 1'b0;
        tsDelay = 16'd0;
        tsByte = 8'h00;
        inverse = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_idle_outputs("reset_state");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_idle_outputs("unpowered_idle");

        run_frame("t1_3b_direct", 400, 8'h3B, 1'b0, 10'b1001110110, 0, 0);
        run_frame("t2_3f_inverse", 100, 8'h3F, 1'b1, 10'b1000000110, 0, 0);
        run_frame("t3_early", 100, 8'h3B, 1'b0, 10'b1001110110, 0, 0);
        run_frame("t3_late", 2000, 8'h3B, 1'b0, 10'b1001110110, 0, 0);
        run_frame("t4_warm_abort", 400, 8'h3B, 1'b0, 10'b1001110110, 400 + 4 * E + E / 2, 1);
        run_frame("t4_fresh", 400, 8'h3B, 1'b0, 10'b1001110110, 0, 0);
        run_frame("t5_vdd_drop", 400, 8'h3B, 1'b0, 10'b1001110110, 50, 2);
        run_frame("t5_sys_reset", 100, 8'h3B, 1'b0, 10'b1001110110, 100 + 3 * E, 3);
        run_frame("t6_3c_direct", 100, 8'h3C, 1'b0, 10'b0001111000, 0, 0);
        run_frame("t7_zero_delay", 0, 8'h3F, 1'b1, 10'b1000000110, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
